// File: rtl/vga_write_arbiter_if.sv
// rtl/vga_write_arbiter_if.sv - engine-side request/grant and pixel lanes shared with the arbiter
interface vga_write_arbiter_if #(
  parameter int N  = 4,
  parameter int nX = 10,
  parameter int nY = 9,
  parameter int nC = 9
);
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic [N*nX-1:0] x_in;
  logic [N*nY-1:0] y_in;
  logic [N*nC-1:0] color_in;
  logic [N-1:0]    write_in;

  modport master (output req, x_in, y_in, color_in, write_in, input grant);
  modport slave  (input req, x_in, y_in, color_in, write_in, output grant);
endinterface

// File: rtl/vga_write_arbiter.sv
// rtl/vga_write_arbiter.sv - round-robin burst arbiter for the single vga_adapter pixel port
module vga_write_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int nX      = 10,
  parameter int nY      = 9,
  parameter int nC      = 9,
  parameter int TIMEOUT = 1024
) (
  input  logic                Clock,
  input  logic                Reset,
  vga_write_arbiter_if.slave  eng,
  output logic [nX-1:0]       VGA_x,
  output logic [nY-1:0]       VGA_y,
  output logic [nC-1:0]       VGA_color,
  output logic                VGA_write,
  output logic [IDW-1:0]      owner,
  output logic                busy,
  output logic [N-1:0]        timeout_flag
);
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t         state;
  logic [N-1:0]   grant_q;
  logic [IDW-1:0] rr_ptr;
  logic [WDW-1:0] wd_cnt;

  logic [nX-1:0] lane_x [N];
  logic [nY-1:0] lane_y [N];
  logic [nC-1:0] lane_c [N];

  logic [IDW-1:0] pick;
  logic           pick_ok;
  logic           sel_wr;
  logic           wd_expire;
  int             idx;

  assign eng.grant = grant_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      lane_x[i] = eng.x_in[i*nX +: nX];
      lane_y[i] = eng.y_in[i*nY +: nY];
      lane_c[i] = eng.color_in[i*nC +: nC];
    end
  end

  // First requester at or after the rr pointer, wrapping modulo N.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(rr_ptr) + i) % N;
      if (!pick_ok && eng.req[idx]) begin
        pick    = IDW'(idx);
        pick_ok = 1'b1;
      end
    end
  end

  assign sel_wr    = eng.write_in[owner];
  assign wd_expire = (TIMEOUT != 0) && !sel_wr && (wd_cnt == WD_LAST);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      grant_q      <= '0;
      VGA_x        <= '0;
      VGA_y        <= '0;
      VGA_color    <= '0;
      VGA_write    <= 1'b0;
      owner        <= '0;
      busy         <= 1'b0;
      timeout_flag <= '0;
      rr_ptr       <= '0;
      wd_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          VGA_write <= 1'b0;
          if (pick_ok) begin
            owner   <= pick;
            grant_q <= N'(1) << pick;
            busy    <= 1'b1;
            wd_cnt  <= '0;
            state   <= OWN;
          end
        end
        OWN: begin
          // The owner's write is forwarded even on the cycle it releases.
          VGA_x     <= lane_x[owner];
          VGA_y     <= lane_y[owner];
          VGA_color <= lane_c[owner];
          VGA_write <= sel_wr;
          if (!eng.req[owner] || wd_expire) begin
            grant_q <= '0;
            busy    <= 1'b0;
            rr_ptr  <= (owner == IDW'(N - 1)) ? '0 : owner + IDW'(1);
            state   <= GAP;
            if (eng.req[owner])
              timeout_flag[owner] <= 1'b1;
          end else begin
            wd_cnt <= sel_wr ? '0 : wd_cnt + WDW'(1);
          end
        end
        GAP: begin
          VGA_write <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          VGA_write <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
- Shares the single pixel-write port of vga_adapter among N sprite-drawing engines (object instances); each engine does its own erase/draw sequencing.
- An engine requests the port, holds it for a whole erase+draw burst, then releases it. Grants are round-robin.
- The owner's x/y/color/write are muxed through one output register stage.
- A watchdog reclaims the port from an owner that stops writing.

Parameters:
- N, 4, number of requesting engines.
- IDW, 2, owner index width; must satisfy 2^IDW >= N.
- nX, 10, VGA x coordinate width.
- nY, 9, VGA y coordinate width.
- nC, 9, pixel color width.
- TIMEOUT, 1024, cycles in OWN without an owner write before forced release; 0 disables the watchdog.

Ports:
- Clock  in  1  system clock (CLOCK_50 domain).
- Reset  in  1  synchronous, active-high reset.
- req  in  N  per-engine request; engine holds it high for the whole burst.
- grant  out  N  one-hot ownership, registered.
- x_in  in  N*nX  packed engine x; engine i uses bits [i*nX +: nX].
- y_in  in  N*nY  packed engine y.
- color_in  in  N*nC  packed engine color.
- write_in  in  N  per-engine pixel write strobe.
- VGA_x  out  nX  to vga_adapter x.
- VGA_y  out  nY  to vga_adapter y.
- VGA_color  out  nC  to vga_adapter color.
- VGA_write  out  1  to vga_adapter write.
- owner  out  IDW  index of current/last owner.
- busy  out  1  high while in OWN.
- timeout_flag  out  N  sticky per-engine flag, set on forced release.

Behaviour:
- Reset (sampled on rising Clock while Reset=1) forces: state=IDLE; grant=0; VGA_x/VGA_y/VGA_color/VGA_write=0; owner=0; busy=0; timeout_flag=0; rr pointer=0; watchdog count=0. Reset wins over all other events, including mid-burst.
- States:
  - IDLE: if req != 0, select the first requester at or after the rr pointer, searching upward modulo N. Register owner, set grant one-hot and busy, go to OWN. If req == 0, stay in IDLE.
  - OWN: forward the owner's lanes each cycle, independent of req.
    - VGA_x/y/color <= owner's x/y/color.
    - VGA_write <= write_in[owner].
    - Leave OWN when req[owner]=0 (normal release) or when the watchdog expires.
    - On exit: grant=0, busy=0, rr pointer <= (owner+1) mod N, go to GAP.
  - GAP: exactly one cycle, VGA_write<=0, no grant; then go to IDLE. A new grant therefore issues at the earliest 2 cycles after release.
- Latency:
  - req rises in IDLE at edge t -> grant visible after edge t+1.
  - An owner write sampled at edge k -> VGA_* valid after edge k+1, for exactly one cycle per strobe.
- Non-owner write_in and data are ignored entirely. In IDLE and GAP, VGA_write<=0 and VGA_x/y/color hold their last value.
- A write in the same cycle req[owner] falls is still forwarded; the release takes effect from the next cycle.
- Watchdog:
  - Counter clears on entry to OWN and on every cycle with write_in[owner]=1; otherwise it increments.
  - When the counter reaches TIMEOUT-1 with no write that cycle: forced release, timeout_flag[owner]<=1.
  - A forcibly released engine whose req stays high is re-eligible, but the rr pointer has already moved past it.
- Simultaneous requests are resolved strictly by rr pointer order. With a single requester, it can re-win after every GAP.
- owner holds its last value outside OWN.
- Indices >= N are never granted.

Test Plan:
- Reset held 3 cycles while req=4'b1111 and write_in=4'b1111 -> grant=0, VGA_write=0, busy=0, timeout_flag=0 throughout.
- req=4'b0100 rises at edge t -> grant=4'b0100 and owner=2 after t+1. Engine 2 writes (x=320,y=240,color=9'h1FF) at edge t+3 -> VGA_x=320, VGA_y=240, VGA_color=1FF, VGA_write=1 after t+4 only. A simultaneous write_in[0] is ignored.
- req=4'b1111 held, each owner drops req after 256 writes -> grant sequence 0,1,2,3,0, with each handover separated by exactly one GAP cycle (VGA_write=0).
- Engine 1 owns and stops writing, TIMEOUT=16 -> grant drops 16 cycles after its last write, timeout_flag=4'b0010, next grant goes to engine 2 if it is requesting.
- Reset asserted mid-burst while engine 3 owns -> all outputs 0 on the next edge. After release with req=4'b1000, engine 3 is re-granted (rr pointer 0).
- Last write coincides with req falling -> that pixel appears on VGA_* one cycle later; no further writes are forwarded.
